data_mem_responder: RTL

//  Data-memory responder for the single-cycle MIPS core's data port: the memory end of the
//  CEN/WEN/OEN/A/Data2Mem/ReadDataMem interface the core drives. Holds DEPTH x 32-bit words.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 26 ++
 rtl/data_mem_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;

  // CLEAR runs the post-reset zeroing sweep; READY serves the core.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_e;

  typedef logic [DMEM_DATA_W-1:0] dmem_word_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage: one synchronous write port, one asynchronous read port.
// The contents are not reset; the owner clears them with a sweep.
module dmem_array #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 32,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: one word per rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port is combinational, so a same-cycle write is not yet visible.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle MIPS core data port.
// Clears the array after reset (busy=1), then serves reads/writes.
// Optional access counters enabled by defining DMEM_ACCESS_STATS_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH        = 128,
  parameter int DATA_W       = DMEM_DATA_W,
  parameter int READ_LATENCY = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   CEN,
  input  logic                   WEN,
  input  logic                   OEN,
  input  logic [DMEM_ADDR_W-1:0] A,
  input  logic [DATA_W-1:0]      Data2Mem,
  output logic [DATA_W-1:0]      ReadDataMem,
  output logic                   busy,
  output logic                   access_err
`ifdef DMEM_ACCESS_STATS_EN
  ,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dmem_state_e       state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic              access_err_q;
  logic [AW-1:0]     addr_idx;
  logic              ready, rd_acc, wr_acc;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Addresses beyond DEPTH wrap; for DEPTH=128 this is the identity.
  assign addr_idx = AW'(32'(A) % DEPTH);

  assign ready  = (state_q == READY);
  assign rd_acc = ready && !CEN && !OEN;
  assign wr_acc = ready && !CEN && !WEN;

  // State and sweep pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state, busy flag and the write-port mux (sweep vs. core).
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_idx;
    mem_wdata = Data2Mem;
    case (state_q)
      CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DEPTH - 1)) state_d = READY;
      end
      READY: begin
        mem_we = wr_acc;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Flag any core access attempted during the sweep, one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) access_err_q <= 1'b0;
    else        access_err_q <= busy && !CEN;
  end
  assign access_err = access_err_q;

  dmem_array #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .AW    (AW)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .raddr_i(addr_idx),
    .rdata_o(mem_rdata)
  );

  generate
    if (READ_LATENCY == 0) begin : g_comb_rd
      // Single-cycle core timing: data appears in the request cycle.
      assign ReadDataMem = rd_acc ? mem_rdata : '0;
    end else begin : g_reg_rd
      logic [DATA_W-1:0] rd_data_q, rd_data_d;
      // Capture on read cycles only; a same-cycle write wins (write-first).
      always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) rd_data_d = wr_acc ? Data2Mem : mem_rdata;
      end
      // Read data register, held between reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
      end
      assign ReadDataMem = rd_data_q;
    end
  endgenerate

`ifdef DMEM_ACCESS_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;
  // Saturating counters of accepted reads and writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_acc && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_acc && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end
  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule
